// File: rtl/matrix_scan_counter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | matrix_scan_counter_if : control/status bundle of the pixel scanner   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface matrix_scan_counter_if #(
  parameter int ROW_W    = 5,
  parameter int COL_W    = 5,
  parameter int SETTLE_W = 8
);
  logic                start_i;
  logic                stop_i;
  logic                continuous_i;
  logic [SETTLE_W-1:0] settle_i;
  logic                ack_i;
  logic [ROW_W-1:0]    row_o;
  logic [COL_W-1:0]    col_o;
  logic                sample_o;
  logic                busy_o;
  logic                frame_done_o;

  modport master (
    output start_i, stop_i, continuous_i, settle_i, ack_i,
    input  row_o, col_o, sample_o, busy_o, frame_done_o
  );

  modport slave (
    input  start_i, stop_i, continuous_i, settle_i, ack_i,
    output row_o, col_o, sample_o, busy_o, frame_done_o
  );
endinterface
`default_nettype wire

// File: rtl/matrix_scan_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | matrix_scan_counter : ROWS x COLS settle/sample/ack scan sequencer    |
// | Option macro SCAN_SERPENTINE_EN: odd rows scan columns in reverse.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module matrix_scan_counter #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int ROW_W    = 5,
  parameter int COL_W    = 5,
  parameter int SETTLE_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  matrix_scan_counter_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

`ifdef SCAN_SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif

  logic [1:0]          state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                cont_q, cont_d;
  logic                sample_q, sample_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  logic                w_rev;
  logic [COL_W-1:0]    w_col_end;
  logic                w_row_end;
  logic                w_last;
  logic [ROW_W-1:0]    w_row_nxt;
  logic [COL_W-1:0]    w_col_nxt;

  // Serpentine keeps the column on a row change; raster snaps back to 0.
  assign w_rev     = SERP && row_q[0];
  assign w_col_end = w_rev ? '0 : COL_LAST;
  assign w_row_end = (col_q == w_col_end);
  assign w_last    = w_row_end && (row_q == ROW_LAST);
  assign w_row_nxt = w_row_end ? ((row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1)) : row_q;
  assign w_col_nxt = w_row_end ? (SERP ? col_q : '0)
                               : (w_rev ? col_q - COL_W'(1) : col_q + COL_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      cnt_q        <= '0;
      settle_q     <= '0;
      cont_q       <= 1'b0;
      sample_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cnt_q        <= cnt_d;
      settle_q     <= settle_d;
      cont_q       <= cont_d;
      sample_q     <= sample_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    cont_d   = cont_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          settle_d = (bus.settle_i == '0) ? SETTLE_W'(1) : bus.settle_i;
          cont_d   = bus.continuous_i;
          row_d    = '0;
          col_d    = '0;
          cnt_d    = settle_d;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (bus.stop_i) begin
          row_d   = '0;
          col_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - SETTLE_W'(1);
          if (cnt_q <= SETTLE_W'(1)) begin
            state_d = ST_SAMPLE;
          end
        end
      end
      ST_SAMPLE: begin
        if (bus.stop_i) begin
          row_d   = '0;
          col_d   = '0;
          state_d = ST_IDLE;
        end else if (bus.ack_i) begin
          if (w_last && !cont_q) begin
            state_d = ST_IDLE;
          end else begin
            row_d   = w_last ? '0 : w_row_nxt;
            col_d   = w_last ? '0 : w_col_nxt;
            cnt_d   = settle_q;
            state_d = ST_SETTLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are precomputed from the next state so they leave flops directly.
  always_comb begin
    sample_d     = (state_d == ST_SAMPLE);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_q == ST_SAMPLE) && bus.ack_i && !bus.stop_i && w_last;
  end

  assign bus.row_o        = row_q;
  assign bus.col_o        = col_q;
  assign bus.sample_o     = sample_q;
  assign bus.busy_o       = busy_q;
  assign bus.frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_matrix_scan_counter : self-checking bench for the 2x3 scanner      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_matrix_scan_counter;
  localparam int ROWS = 2, COLS = 3, ROW_W = 5, COL_W = 5, SETTLE_W = 8;
  localparam int NPIX = ROWS * COLS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_scan_counter_if #(.ROW_W(ROW_W), .COL_W(COL_W), .SETTLE_W(SETTLE_W)) bus ();

  matrix_scan_counter #(
    .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W), .SETTLE_W(SETTLE_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] c;
  } pix_t;

  typedef struct {
    int settle;
    int lat;
  } settle_vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  pix_t sb_q[$];
  pix_t order[NPIX];
  logic prev_s = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every rising sample_o must match the next queued pixel.
  always @(negedge clk) begin
    if (bus.sample_o && !prev_s) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected sample: got (%0d,%0d), expected none", bus.row_o, bus.col_o);
      end else begin
        pix_t p;
        p = sb_q.pop_front();
        check("sample row", 32'(bus.row_o), 32'(p.r));
        check("sample col", 32'(bus.col_o), 32'(p.c));
      end
    end
    prev_s <= bus.sample_o;
  end

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) sb_q.push_back(order[i]);
  endtask

  task automatic push_origin();
    pix_t p;
    p.r = '0;
    p.c = '0;
    sb_q.push_back(p);
  endtask

  task automatic start_scan(input int s, input bit cont);
    bus.settle_i     = SETTLE_W'(s);
    bus.continuous_i = cont;
    bus.start_i      = 1'b1;
    @(negedge clk);
    bus.start_i      = 1'b0;
    bus.settle_i     = ~SETTLE_W'(s);
    bus.continuous_i = ~cont;
    check("start busy", 32'(bus.busy_o), 32'd1);
    check("start row", 32'(bus.row_o), 32'd0);
    check("start col", 32'(bus.col_o), 32'd0);
  endtask

  task automatic wait_sample(output int lat);
    lat = 0;
    while (!bus.sample_o && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic stop_scan();
    bus.stop_i = 1'b1;
    @(negedge clk);
    bus.stop_i = 1'b0;
    check("stop busy", 32'(bus.busy_o), 32'd0);
    check("stop sample", 32'(bus.sample_o), 32'd0);
    check("stop frame_done", 32'(bus.frame_done_o), 32'd0);
  endtask

  initial begin
    settle_vec_t vecs[5];
    int   lat, cyc, fd;
    bit   serp, stall_ok;
    pix_t last;

    vecs[0] = '{settle: 1,   lat: 1};
    vecs[1] = '{settle: 2,   lat: 2};
    vecs[2] = '{settle: 5,   lat: 5};
    vecs[3] = '{settle: 0,   lat: 1};
    vecs[4] = '{settle: 255, lat: 255};

`ifdef SCAN_SERPENTINE_EN
    serp = 1'b1;
`else
    serp = 1'b0;
`endif
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        order[r*COLS + c].r = ROW_W'(r);
        order[r*COLS + c].c = COL_W'((serp && (r % 2 == 1)) ? (COLS - 1 - c) : c);
      end
    end
    last = order[NPIX-1];

    bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.continuous_i = 1'b0;
    bus.settle_i = '0;  bus.ack_i = 1'b0;

    repeat (3) @(negedge clk);
    check("reset row", 32'(bus.row_o), 32'd0);
    check("reset col", 32'(bus.col_o), 32'd0);
    check("reset sample", 32'(bus.sample_o), 32'd0);
    check("reset busy", 32'(bus.busy_o), 32'd0);
    check("reset frame_done", 32'(bus.frame_done_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Settle latency table: cycles from the start edge to sample_o high.
    for (int i = 0; i < 5; i++) begin
      push_origin();
      start_scan(vecs[i].settle, 1'b0);
      wait_sample(lat);
      check("settle latency", 32'(lat), 32'(vecs[i].lat));
      stop_scan();
    end

    // Single frame with immediate acks.
    push_frame();
    start_scan(2, 1'b0);
    fd = 0; cyc = 0;
    while (cyc < 200) begin
      if (bus.frame_done_o) fd++;
      if (!bus.busy_o) break;
      bus.ack_i = bus.sample_o;
      @(negedge clk);
      cyc++;
    end
    bus.ack_i = 1'b0;
    check("single frame in time", 32'(cyc < 200), 32'd1);
    check("single frame_done count", 32'(fd), 32'd1);
    check("single end busy", 32'(bus.busy_o), 32'd0);
    check("single end row", 32'(bus.row_o), 32'(last.r));
    check("single end col", 32'(bus.col_o), 32'(last.c));
    @(negedge clk);
    check("frame_done one cycle", 32'(bus.frame_done_o), 32'd0);
    check("single hold row", 32'(bus.row_o), 32'(last.r));

    // Ack stall: position and sample_o must hold for 10 cycles without ack.
    push_origin();
    start_scan(1, 1'b0);
    wait_sample(lat);
    stall_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(bus.sample_o && bus.row_o == 0 && bus.col_o == 0)) stall_ok = 1'b0;
    end
    check("stall stable", 32'(stall_ok), 32'd1);
    bus.ack_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;
    check("post-ack sample", 32'(bus.sample_o), 32'd0);
    check("post-ack row", 32'(bus.row_o), 32'(order[1].r));
    check("post-ack col", 32'(bus.col_o), 32'(order[1].c));
    stop_scan();
    check("stop row", 32'(bus.row_o), 32'd0);

    // Continuous wrap back to (0,0).
    push_frame();
    push_origin();
    start_scan(1, 1'b1);
    cyc = 0;
    while (cyc < 200 && !bus.frame_done_o) begin
      bus.ack_i = bus.sample_o;
      @(negedge clk);
      cyc++;
    end
    bus.ack_i = 1'b0;
    check("cont frame_done", 32'(bus.frame_done_o), 32'd1);
    check("cont busy", 32'(bus.busy_o), 32'd1);
    check("cont wrap row", 32'(bus.row_o), 32'd0);
    check("cont wrap col", 32'(bus.col_o), 32'd0);
    wait_sample(lat);
    check("cont resample latency", 32'(lat), 32'd1);
    stop_scan();

    // stop_i and ack_i together on the last pixel.
    push_frame();
    start_scan(1, 1'b0);
    cyc = 0;
    while (cyc < 200 && !(bus.sample_o && bus.row_o == last.r && bus.col_o == last.c)) begin
      bus.ack_i = bus.sample_o;
      @(negedge clk);
      cyc++;
    end
    check("reach last pixel", 32'(cyc < 200), 32'd1);
    bus.stop_i = 1'b1;
    bus.ack_i  = 1'b1;
    @(negedge clk);
    bus.stop_i = 1'b0;
    bus.ack_i  = 1'b0;
    check("stop+ack busy", 32'(bus.busy_o), 32'd0);
    check("stop+ack row", 32'(bus.row_o), 32'd0);
    check("stop+ack col", 32'(bus.col_o), 32'd0);
    check("stop+ack frame_done", 32'(bus.frame_done_o), 32'd0);
    @(negedge clk);
    check("stop+ack no late pulse", 32'(bus.frame_done_o), 32'd0);

    // Asynchronous reset in the middle of the second pixel's settle.
    push_origin();
    start_scan(4, 1'b0);
    wait_sample(lat);
    bus.ack_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;
    @(negedge clk);
    check("pre-reset col", 32'(bus.col_o), 32'(order[1].c));
    #1 rst = 1'b1;
    #1;
    check("async rst busy", 32'(bus.busy_o), 32'd0);
    check("async rst row", 32'(bus.row_o), 32'd0);
    check("async rst col", 32'(bus.col_o), 32'd0);
    check("async rst sample", 32'(bus.sample_o), 32'd0);
    check("async rst frame_done", 32'(bus.frame_done_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
